// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode bit positions in the config word, peripheral
// states, and the byte sent when the TX holding register is empty.
package spi_pkg;

    localparam int CFG_CPOL_BIT  = 2;
    localparam int CFG_CPHA_BIT  = 1;
    localparam int CFG_STORE_BIT = 0;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    localparam logic [7:0] UNDERRUN_FILL = 8'h00;

endpackage

// File: rtl/spi_peripheral_if.sv
// Device-side byte interface of the SPI peripheral (fabric = master, peripheral = slave).
interface spi_peripheral_if;

    // TX: a byte transfers on every i_clk edge where i_tx_valid && o_tx_ready;
    // i_tx must be stable while i_tx_valid is high. RX: o_rx is valid only in
    // the single cycle o_rx_valid is high; there is no back-pressure on RX.
    logic [7:0] i_tx;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx;
    logic       o_rx_valid;
    logic       o_tx_underrun;

    modport master (
        output i_tx, i_tx_valid,
        input  o_tx_ready, o_rx, o_rx_valid, o_tx_underrun
    );

    modport slave (
        input  i_tx, i_tx_valid,
        output o_tx_ready, o_rx, o_rx_valid, o_tx_underrun
    );

endinterface

// File: rtl/spi_pin_sync.sv
// N-stage synchronizer plus edge detector for one asynchronous pin.
// Flops reset low, so a fall is only reported after the pin has been seen high.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_rise = sync_q[STAGES-1] & ~prev_q;
    assign o_fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral (target), modes 0-3, oversampled in the i_clk domain.
// Define SPI_PERIPHERAL_UNDERRUN_EN to enable o_tx_underrun pulses (tied 0 otherwise).
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_config,
    spi_peripheral_if.slave  bus,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_copi,
    output logic             o_cipo,
    output logic             o_cipo_en,
    output logic             o_busy,
    output spi_state_t       o_dbg_state
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pin  (i_sclk),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pin  (i_cs_n),
        .o_rise (cs_rise),
        .o_fall (cs_fall)
    );

    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   copi_s;
    spi_mode_t              mode_q;
    spi_state_t             state_q, state_d;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             rx_shift_q;
    logic [7:0]             tx_shift_q, hold_q, rx_q, load_byte;
    logic                   hold_full_q, rx_valid_q, cipo_q;
    logic                   sclk_lead, sclk_trail, sample_stb, drive_stb;
    logic                   in_shift, reload, tx_accept;

    assign copi_s     = copi_sync_q[SYNC_STAGES-1];
    assign sclk_lead  = mode_q.cpol ? sclk_fall : sclk_rise;
    assign sclk_trail = mode_q.cpol ? sclk_rise : sclk_fall;
    assign sample_stb = mode_q.cpha ? sclk_trail : sclk_lead;
    assign drive_stb  = mode_q.cpha ? sclk_lead  : sclk_trail;
    assign in_shift   = (state_q == ST_SHIFT) && !cs_rise;

    // First drive event of each byte pulls from the holding register; for
    // CPHA=0 byte 0 that event is the CS fall itself.
    assign reload    = (state_q == ST_IDLE && cs_fall && !mode_q.cpha)
                     || (in_shift && drive_stb && bit_cnt_q == 3'd0);
    assign load_byte = hold_full_q ? hold_q : UNDERRUN_FILL;
    assign tx_accept = bus.i_tx_valid && !hold_full_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            copi_sync_q <= '0;
            mode_q      <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_q        <= '0;
            rx_valid_q  <= 1'b0;
            cipo_q      <= 1'b0;
        end else begin
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], i_copi};
            rx_valid_q  <= 1'b0;
            if (state_q == ST_IDLE && i_config[CFG_STORE_BIT])
                mode_q <= '{cpol: i_config[CFG_CPOL_BIT], cpha: i_config[CFG_CPHA_BIT]};

            // A write in the reload cycle is kept for the following byte.
            if (tx_accept) hold_q <= bus.i_tx;
            hold_full_q <= (hold_full_q && !reload) || tx_accept;

            if (reload) begin
                cipo_q     <= load_byte[7];
                tx_shift_q <= {load_byte[6:0], 1'b0};
            end else if (in_shift && drive_stb) begin
                cipo_q     <= tx_shift_q[7];
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end else if (state_q == ST_IDLE) begin
                cipo_q <= 1'b0;
            end

            if ((state_q == ST_IDLE && cs_fall) || (state_q == ST_SHIFT && cs_rise)) begin
                bit_cnt_q <= '0;
            end else if (in_shift && sample_stb) begin
                rx_shift_q <= {rx_shift_q[5:0], copi_s};
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_q       <= {rx_shift_q, copi_s};
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_PERIPHERAL_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) underrun_q <= 1'b0;
        else          underrun_q <= reload && !hold_full_q;
    end

    assign bus.o_tx_underrun = underrun_q;
`else
    assign bus.o_tx_underrun = 1'b0;
`endif

    assign bus.o_tx_ready = ~hold_full_q;
    assign bus.o_rx       = rx_q;
    assign bus.o_rx_valid = rx_valid_q;
    assign o_cipo         = cipo_q;
    assign o_cipo_en      = (state_q == ST_SHIFT);
    assign o_busy         = (state_q == ST_SHIFT);
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed scenarios plus random frames, with an
// SPI controller model and a queue-based model of the TX/RX byte streams.
module tb_spi_peripheral;
    import spi_pkg::*;

    localparam int HALF = 8;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
    localparam bit UNDERRUN_EN = 1'b1;
`else
    localparam bit UNDERRUN_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [2:0] i_config;
    logic       i_sclk, i_cs_n, i_copi;
    logic       o_cipo, o_cipo_en, o_busy;
    spi_state_t o_dbg_state;

    spi_peripheral_if bus ();

    spi_peripheral #(.SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_config   (i_config),
        .bus        (bus),
        .i_sclk     (i_sclk),
        .i_cs_n     (i_cs_n),
        .i_copi     (i_copi),
        .o_cipo     (o_cipo),
        .o_cipo_en  (o_cipo_en),
        .o_busy     (o_busy),
        .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    int         n_assert = 0;
    int         n_fail = 0;
    int         underrun_seen = 0;
    logic [7:0] exp_q[$];    // bytes the peripheral must report on o_rx, in order
    logic [7:0] avail_q[$];  // bytes handed to the peripheral, not yet loaded for sending
    logic [7:0] feed_q[$];   // bytes the fabric driver has still to write

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One i_clk cycle: monitor RX/underrun and run the fabric-side TX driver.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (bus.o_rx_valid) begin
            if (exp_q.size() > 0) check("rx_byte", {24'h0, bus.o_rx}, {24'h0, exp_q.pop_front()});
            else                  check("rx_valid_spurious", {31'h0, bus.o_rx_valid}, 32'h0);
        end
        if (bus.o_tx_underrun) underrun_seen++;
        if (bus.i_tx_valid) begin
            bus.i_tx_valid = 1'b0;
            void'(feed_q.pop_front());
        end else if (feed_q.size() > 0 && bus.o_tx_ready) begin
            bus.i_tx       = feed_q[0];
            bus.i_tx_valid = 1'b1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_mode(input logic [1:0] m);
        i_config = {m, 1'b1};
        tick();
        i_config = 3'b000;
        tick();
    endtask

    task automatic feed(input logic [7:0] b);
        feed_q.push_back(b);
        avail_q.push_back(b);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx"},       {24'h0, bus.o_rx}, 32'h0);
        check({tag, "_rx_valid"}, {31'h0, bus.o_rx_valid}, 32'h0);
        check({tag, "_tx_ready"}, {31'h0, bus.o_tx_ready}, 32'h1);
        check({tag, "_underrun"}, {31'h0, bus.o_tx_underrun}, 32'h0);
        check({tag, "_cipo"},     {31'h0, o_cipo}, 32'h0);
        check({tag, "_cipo_en"},  {31'h0, o_cipo_en}, 32'h0);
        check({tag, "_busy"},     {31'h0, o_busy}, 32'h0);
        check({tag, "_state"},    32'(o_dbg_state), 32'(ST_IDLE));
    endtask

    // Controller: clocks nbits of mosi (MSB first) and returns what it read on cipo.
    task automatic spi_frame(input logic [1:0] mode, input int nbits, input logic [31:0] mosi,
                             input logic [2:0] mid_cfg, output logic [31:0] miso);
        logic        cpol, cpha;
        logic [31:0] sh;
        cpol = mode[1];
        cpha = mode[0];
        sh   = mosi;
        miso = '0;
        i_sclk = cpol;
        ticks(4);
        i_cs_n = 1'b0;
        if (!cpha) begin
            i_copi = sh[31];
            sh = sh << 1;
        end
        ticks(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                miso = {miso[30:0], o_cipo};
                i_sclk = ~cpol;
                ticks(HALF);
                i_sclk = cpol;
                i_copi = sh[31];
                sh = sh << 1;
            end else begin
                i_sclk = ~cpol;
                i_copi = sh[31];
                sh = sh << 1;
                ticks(HALF);
                miso = {miso[30:0], o_cipo};
                i_sclk = cpol;
            end
            if (mid_cfg[0] && i == 2) begin
                i_config = mid_cfg;
                tick();
                i_config = 3'b000;
                ticks(HALF - 1);
            end else begin
                ticks(HALF);
            end
        end
        i_cs_n = 1'b1;
        ticks(2 * HALF);
    endtask

    // Each byte slot that starts takes the oldest queued byte, else 0x00 with
    // an underrun. With CPHA=0 the trailing edge after every 8th bit opens a
    // new slot, so a frame opens one more slot than it completes.
    task automatic run_frame(input logic [1:0] mode, input int nbits, input logic [31:0] mosi,
                             input logic [2:0] mid_cfg);
        int          nfull, nslots, exp_under, under0;
        logic [7:0]  exp_miso[$];
        logic [31:0] m, miso;
        nfull     = nbits / 8;
        nslots    = mode[0] ? (nbits + 7) / 8 : nfull + 1;
        exp_under = 0;
        under0    = underrun_seen;
        for (int k = 0; k < nslots; k++) begin
            if (avail_q.size() > 0) exp_miso.push_back(avail_q.pop_front());
            else begin
                exp_miso.push_back(8'h00);
                exp_under++;
            end
        end
        m = mosi;
        for (int k = 0; k < nfull; k++) begin
            exp_q.push_back(m[31:24]);
            m = m << 8;
        end
        spi_frame(mode, nbits, mosi, mid_cfg, miso);
        for (int k = 0; k < nfull; k++)
            check("miso_byte", {24'h0, miso[(nbits - 1 - 8 * k) -: 8]}, {24'h0, exp_miso[k]});
        check("underrun_count", underrun_seen - under0, UNDERRUN_EN ? exp_under : 0);
        check("rx_drained", exp_q.size(), 0);
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_config       = 3'b000;
        i_sclk         = 1'b0;
        i_cs_n         = 1'b1;
        i_copi         = 1'b0;
        bus.i_tx       = 8'h00;
        bus.i_tx_valid = 1'b0;
        ticks(3);
        check_reset_values("reset");
        i_rst_n = 1'b1;
        ticks(2 * HALF);

        // Mode 0, preloaded byte
        feed(8'hA5);
        ticks(3);
        check("tx_ready_after_write", {31'h0, bus.o_tx_ready}, 32'h0);
        run_frame(2'd0, 8, {8'h3C, 24'h0}, 3'b000);

        // Mode 3, two-byte frame
        set_mode(2'd3);
        feed(8'h12);
        feed(8'h34);
        run_frame(2'd3, 16, {8'hF0, 8'h0F, 16'h0}, 3'b000);

        // Mode 1, nothing queued
        set_mode(2'd1);
        run_frame(2'd1, 8, {8'h6B, 24'h0}, 3'b000);

        // Frame aborted after 5 bits, then a clean mode 0 frame
        set_mode(2'd0);
        feed(8'h11);
        run_frame(2'd0, 5, {8'hA8, 24'h0}, 3'b000);
        feed(8'h22);
        run_frame(2'd0, 8, {8'h81, 24'h0}, 3'b000);

        // Config strobe mid-frame is ignored; in IDLE it takes effect
        feed(8'h5A);
        run_frame(2'd0, 8, {8'hC7, 24'h0}, 3'b111);
        feed(8'hE1);
        run_frame(2'd0, 8, {8'h1E, 24'h0}, 3'b000);
        set_mode(2'd3);
        feed(8'h77);
        run_frame(2'd3, 8, {8'h99, 24'h0}, 3'b000);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            logic [1:0]  rm;
            int          nb, nf;
            logic [31:0] rmosi;
            rm    = 2'($urandom_range(0, 3));
            nb    = $urandom_range(1, 3);
            nf    = $urandom_range(0, nb + 1);
            rmosi = $urandom;
            set_mode(rm);
            for (int f = 0; f < nf; f++) feed(8'($urandom_range(0, 255)));
            run_frame(rm, 8 * nb, rmosi, 3'b000);
        end

        // Reset in the middle of a byte
        set_mode(2'd0);
        feed(8'hC3);
        ticks(4);
        i_sclk = 1'b0;
        i_cs_n = 1'b0;
        i_copi = 1'b1;
        ticks(HALF);
        i_sclk = 1'b1;
        ticks(HALF);
        i_sclk = 1'b0;
        ticks(3);
        check("busy_mid_frame", {31'h0, o_busy}, 32'h1);
        i_rst_n = 1'b0;
        tick();
        check_reset_values("mid_reset");
        avail_q.delete();
        feed_q.delete();
        ticks(2);
        i_rst_n = 1'b1;
        ticks(2 * HALF);
        check("cs_low_at_release_busy", {31'h0, o_busy}, 32'h0);
        check("cs_low_at_release_state", 32'(o_dbg_state), 32'(ST_IDLE));
        i_cs_n = 1'b1;
        ticks(HALF);
        feed(8'h69);
        run_frame(2'd0, 8, {8'h96, 24'h0}, 3'b000);

        check("final_rx_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
